// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by the fetch unit and by anything that consumes its outputs.
package rv_fetch_pkg;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   localparam logic [31:0] FETCH_BUBBLE     = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Signals between the fetch unit, its synchronous instruction memory,
// the downstream compressed buffer and the execute-stage redirect source.
interface fetch_unit_if #(
   parameter int ADDR_W = 12
);
   logic              stall_in;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [31:0]       fetch_inst;
   logic [31:0]       fetch_pc;
   logic              fetch_valid;
   logic              fetch_hi_only;
   logic              flush_out;

   modport master (
      input  stall_in, redirect, redirect_pc, imem_rdata,
      output imem_addr, fetch_inst, fetch_pc, fetch_valid, fetch_hi_only, flush_out
   );

   modport slave (
      output stall_in, redirect, redirect_pc, imem_rdata,
      input  imem_addr, fetch_inst, fetch_pc, fetch_valid, fetch_hi_only, flush_out
   );
endinterface

// File: rtl/fetch_unit.sv
// Word-aligned fetch stage: owns the PC, addresses a synchronous imem and
// presents one word per cycle, replaying on stall and honouring redirects.
module fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter int          ADDR_W   = 12,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);

   fetch_state_t      state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic              valid_q, valid_d;
   logic              hi_q, hi_d;
   logic [ADDR_W-1:0] pc_word;
   logic [ADDR_W-1:0] imem_addr_d;
   logic              unused_bit;

   assign pc_word    = pc_q[ADDR_W+1:2];
   assign unused_bit = bus.redirect_pc[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         hi_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         hi_q    <= hi_d;
      end
   end

   // The address issued this cycle is the word that will be shown next
   // cycle, so it follows the same priority as the PC update.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      valid_d     = valid_q;
      hi_d        = hi_q;
      imem_addr_d = pc_word + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (state_q == BOOT) begin
         state_d = RUN;
         pc_d    = RESET_PC;
         valid_d = 1'b1;
         hi_d    = 1'b0;
      end else if (bus.redirect) begin
         pc_d    = {bus.redirect_pc[31:2], 2'b00};
         valid_d = 1'b1;
         hi_d    = bus.redirect_pc[1];
      end else if (bus.stall_in && valid_q) begin
         imem_addr_d = pc_word;
      end else begin
         pc_d = pc_q + 32'd4;
         hi_d = 1'b0;
      end
      if (rst || state_q == BOOT) begin
         imem_addr_d = RESET_PC[ADDR_W+1:2];
      end else if (bus.redirect) begin
         imem_addr_d = bus.redirect_pc[ADDR_W+1:2];
      end
   end

   assign bus.imem_addr     = imem_addr_d;
   assign bus.fetch_inst    = valid_q ? bus.imem_rdata : FETCH_BUBBLE;
   assign bus.fetch_pc      = pc_q;
   assign bus.fetch_valid   = valid_q;
   assign bus.fetch_hi_only = hi_q & valid_q;
   assign bus.flush_out     = bus.redirect;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: boot, sequential fetch, stall
// replay, redirects (halfword, during stall, back-to-back), async reset, wrap.
module tb_fetch_unit;
   import rv_fetch_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(12)) bif ();
   fetch_unit_if #(.ADDR_W(4))  bif4 ();

   fetch_unit #(.ADDR_W(12), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bif.master));
   fetch_unit #(.ADDR_W(4),  .RESET_PC(32'h0)) dut4 (.clk(clk), .rst(rst), .bus(bif4.master));

   logic [31:0] mem  [0:4095];
   logic [31:0] mem4 [0:15];

   always @(posedge clk) begin
      bif.imem_rdata  <= mem[bif.imem_addr];
      bif4.imem_rdata <= mem4[bif4.imem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
      $display("t=%0t pc=%h inst=%h valid=%b hi=%b addr=%h flush=%b", $time,
               bif.fetch_pc, bif.fetch_inst, bif.fetch_valid, bif.fetch_hi_only,
               bif.imem_addr, bif.flush_out);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bif.stall_in = 1'b0; bif.redirect = 1'b0; bif.redirect_pc = 32'h0;
      bif4.stall_in = 1'b0; bif4.redirect = 1'b0; bif4.redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bif.fetch_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bif.fetch_valid); else passed++;
      total++; if (bif.fetch_inst !== 32'h0) $display("FAIL rst_inst got=%h exp=0", bif.fetch_inst); else passed++;
      total++; if (bif.fetch_pc !== 32'h0) $display("FAIL rst_pc got=%h exp=0", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_hi_only !== 1'b0) $display("FAIL rst_hi got=%b exp=0", bif.fetch_hi_only); else passed++;
      total++; if (bif.flush_out !== 1'b0) $display("FAIL rst_flush got=%b exp=0", bif.flush_out); else passed++;
      total++; if (bif.imem_addr !== 12'h0) $display("FAIL rst_addr got=%h exp=0", bif.imem_addr); else passed++;
      bif.redirect = 1'b1; bif.redirect_pc = 32'h400;
      #1;
      total++; if (bif.flush_out !== 1'b1) $display("FAIL rst_redir_flush got=%b exp=1", bif.flush_out); else passed++;
      total++; if (bif.imem_addr !== 12'h0) $display("FAIL rst_redir_addr got=%h exp=0", bif.imem_addr); else passed++;
      bif.redirect = 1'b0;
      rst = 1'b0;
      #1;
      total++; if (bif.imem_addr !== 12'h0) $display("FAIL boot_addr got=%h exp=0", bif.imem_addr); else passed++;
      total++; if (bif.fetch_valid !== 1'b0) $display("FAIL boot_valid got=%b exp=0", bif.fetch_valid); else passed++;
      step();
      total++; if (bif.fetch_valid !== 1'b1) $display("FAIL first_valid got=%b exp=1", bif.fetch_valid); else passed++;
      total++; if (bif.fetch_pc !== 32'h0) $display("FAIL first_pc got=%h exp=0", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_inst !== 32'h0) $display("FAIL first_inst got=%h exp=0", bif.fetch_inst); else passed++;
      total++; if (bif.imem_addr !== 12'h1) $display("FAIL first_addr got=%h exp=1", bif.imem_addr); else passed++;
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 2; i++) begin
         step();
         total++; if (bif.fetch_pc !== 32'(4 * i)) $display("FAIL seq_pc got=%h exp=%h", bif.fetch_pc, 32'(4 * i)); else passed++;
         total++; if (bif.fetch_inst !== 32'(i)) $display("FAIL seq_inst got=%h exp=%h", bif.fetch_inst, 32'(i)); else passed++;
         total++; if (bif.imem_addr !== 12'(i + 1)) $display("FAIL seq_addr got=%h exp=%h", bif.imem_addr, 12'(i + 1)); else passed++;
      end
   endtask

   task automatic test_stall();
      bif.stall_in = 1'b1;
      #1;
      total++; if (bif.imem_addr !== 12'h2) $display("FAIL stall_addr0 got=%h exp=2", bif.imem_addr); else passed++;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bif.fetch_pc !== 32'h8) $display("FAIL stall_pc got=%h exp=8", bif.fetch_pc); else passed++;
         total++; if (bif.fetch_inst !== 32'h2) $display("FAIL stall_inst got=%h exp=2", bif.fetch_inst); else passed++;
         total++; if (bif.imem_addr !== 12'h2) $display("FAIL stall_addr got=%h exp=2", bif.imem_addr); else passed++;
      end
      bif.stall_in = 1'b0;
      #1;
      total++; if (bif.imem_addr !== 12'h3) $display("FAIL unstall_addr got=%h exp=3", bif.imem_addr); else passed++;
      step();
      total++; if (bif.fetch_pc !== 32'hC) $display("FAIL unstall_pc got=%h exp=c", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_inst !== 32'h3) $display("FAIL unstall_inst got=%h exp=3", bif.fetch_inst); else passed++;
   endtask

   task automatic test_redirect();
      bif.redirect = 1'b1; bif.redirect_pc = 32'h46;
      #1;
      total++; if (bif.flush_out !== 1'b1) $display("FAIL redir_flush got=%b exp=1", bif.flush_out); else passed++;
      total++; if (bif.imem_addr !== 12'h11) $display("FAIL redir_addr got=%h exp=11", bif.imem_addr); else passed++;
      step();
      bif.redirect = 1'b0;
      #1;
      total++; if (bif.fetch_pc !== 32'h44) $display("FAIL redir_pc got=%h exp=44", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_hi_only !== 1'b1) $display("FAIL redir_hi got=%b exp=1", bif.fetch_hi_only); else passed++;
      total++; if (bif.fetch_inst !== 32'h11) $display("FAIL redir_inst got=%h exp=11", bif.fetch_inst); else passed++;
      total++; if (bif.flush_out !== 1'b0) $display("FAIL redir_flush_clr got=%b exp=0", bif.flush_out); else passed++;
      step();
      total++; if (bif.fetch_pc !== 32'h48) $display("FAIL redir_next_pc got=%h exp=48", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_hi_only !== 1'b0) $display("FAIL redir_next_hi got=%b exp=0", bif.fetch_hi_only); else passed++;
      total++; if (bif.fetch_inst !== 32'h12) $display("FAIL redir_next_inst got=%h exp=12", bif.fetch_inst); else passed++;
   endtask

   task automatic test_redirect_stall();
      bif.stall_in = 1'b1; bif.redirect = 1'b1; bif.redirect_pc = 32'h100;
      #1;
      total++; if (bif.flush_out !== 1'b1) $display("FAIL rs_flush got=%b exp=1", bif.flush_out); else passed++;
      total++; if (bif.imem_addr !== 12'h40) $display("FAIL rs_addr got=%h exp=40", bif.imem_addr); else passed++;
      step();
      bif.stall_in = 1'b0; bif.redirect = 1'b0;
      total++; if (bif.fetch_pc !== 32'h100) $display("FAIL rs_pc got=%h exp=100", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_hi_only !== 1'b0) $display("FAIL rs_hi got=%b exp=0", bif.fetch_hi_only); else passed++;
      total++; if (bif.fetch_inst !== 32'h40) $display("FAIL rs_inst got=%h exp=40", bif.fetch_inst); else passed++;
   endtask

   task automatic test_back_to_back();
      bif.redirect = 1'b1; bif.redirect_pc = 32'h202;
      #1;
      total++; if (bif.imem_addr !== 12'h80) $display("FAIL b2b_addr1 got=%h exp=80", bif.imem_addr); else passed++;
      step();
      total++; if (bif.fetch_pc !== 32'h200) $display("FAIL b2b_pc1 got=%h exp=200", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_hi_only !== 1'b1) $display("FAIL b2b_hi1 got=%b exp=1", bif.fetch_hi_only); else passed++;
      bif.redirect_pc = 32'h300;
      #1;
      total++; if (bif.flush_out !== 1'b1) $display("FAIL b2b_flush2 got=%b exp=1", bif.flush_out); else passed++;
      total++; if (bif.imem_addr !== 12'hC0) $display("FAIL b2b_addr2 got=%h exp=c0", bif.imem_addr); else passed++;
      step();
      bif.redirect = 1'b0;
      total++; if (bif.fetch_pc !== 32'h300) $display("FAIL b2b_pc2 got=%h exp=300", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_hi_only !== 1'b0) $display("FAIL b2b_hi2 got=%b exp=0", bif.fetch_hi_only); else passed++;
      total++; if (bif.fetch_inst !== 32'hC0) $display("FAIL b2b_inst2 got=%h exp=c0", bif.fetch_inst); else passed++;
      // hi_only must survive a stall on the first word after a halfword redirect
      bif.redirect = 1'b1; bif.redirect_pc = 32'h206;
      step();
      bif.redirect = 1'b0; bif.stall_in = 1'b1;
      step();
      total++; if (bif.fetch_pc !== 32'h204) $display("FAIL hold_pc got=%h exp=204", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_hi_only !== 1'b1) $display("FAIL hold_hi got=%b exp=1", bif.fetch_hi_only); else passed++;
      total++; if (bif.fetch_inst !== 32'h81) $display("FAIL hold_inst got=%h exp=81", bif.fetch_inst); else passed++;
      bif.stall_in = 1'b0;
      step();
      total++; if (bif.fetch_pc !== 32'h208) $display("FAIL hold_next_pc got=%h exp=208", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_hi_only !== 1'b0) $display("FAIL hold_next_hi got=%b exp=0", bif.fetch_hi_only); else passed++;
      total++; if (bif.fetch_inst !== 32'h82) $display("FAIL hold_next_inst got=%h exp=82", bif.fetch_inst); else passed++;
   endtask

   task automatic test_async_reset();
      bif.stall_in = 1'b1;
      step();
      #2;
      rst = 1'b1;
      #1;
      total++; if (bif.fetch_valid !== 1'b0) $display("FAIL arst_valid got=%b exp=0", bif.fetch_valid); else passed++;
      total++; if (bif.fetch_inst !== 32'h0) $display("FAIL arst_inst got=%h exp=0", bif.fetch_inst); else passed++;
      total++; if (bif.fetch_pc !== 32'h0) $display("FAIL arst_pc got=%h exp=0", bif.fetch_pc); else passed++;
      total++; if (bif.imem_addr !== 12'h0) $display("FAIL arst_addr got=%h exp=0", bif.imem_addr); else passed++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      total++; if (bif.fetch_valid !== 1'b0) $display("FAIL reboot_valid0 got=%b exp=0", bif.fetch_valid); else passed++;
      step();
      bif.stall_in = 1'b0;
      total++; if (bif.fetch_valid !== 1'b1) $display("FAIL reboot_valid got=%b exp=1", bif.fetch_valid); else passed++;
      total++; if (bif.fetch_pc !== 32'h0) $display("FAIL reboot_pc got=%h exp=0", bif.fetch_pc); else passed++;
      step();
      total++; if (bif.fetch_pc !== 32'h4) $display("FAIL reboot_pc2 got=%h exp=4", bif.fetch_pc); else passed++;
      total++; if (bif.fetch_inst !== 32'h1) $display("FAIL reboot_inst2 got=%h exp=1", bif.fetch_inst); else passed++;
   endtask

   task automatic test_wrap();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         total++; if (bif4.fetch_pc !== 32'(4 * i)) $display("FAIL wrap_pc got=%h exp=%h", bif4.fetch_pc, 32'(4 * i)); else passed++;
         total++; if (bif4.fetch_inst !== 32'(32'hA0 + (i % 16))) $display("FAIL wrap_inst got=%h exp=%h", bif4.fetch_inst, 32'(32'hA0 + (i % 16))); else passed++;
         total++; if (bif4.imem_addr !== 4'((i + 1) % 16)) $display("FAIL wrap_addr got=%h exp=%h", bif4.imem_addr, 4'((i + 1) % 16)); else passed++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int n = 0; n < 4096; n++) mem[n] = 32'(n);
      for (int n = 0; n < 16; n++) mem4[n] = 32'(32'hA0 + n);
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_back_to_back();
      test_async_reset();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
